// File: rtl/blob_centroid_det_pkg.sv
// Shared types and width helpers for the blob centroid detector.
package blob_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } blobState_t;

  // Hit counter must hold every pixel of a frame, including the all-hit case.
  function automatic int cntWidth(input int frameW, input int frameH);
    return $clog2(frameW * frameH + 1);
  endfunction

  function automatic int divWidth(input int cntW, input int coordW);
    return cntW + coordW;
  endfunction

endpackage

// File: rtl/blob_centroid_det_if.sv
// Pixel stream in / centroid result out bundle for blob_centroid_det.
// Bounding-box result signals exist only when BLOB_BBOX_EN is defined.
interface blob_centroid_det_if #(
  parameter int PIX_W   = 12,
  parameter int COORD_W = 11,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
);
  localparam int CNT_W = blob_pkg::cntWidth(FRAME_W, FRAME_H);

  logic [PIX_W-1:0]   iColor;
  logic               iDVAL;
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  logic [PIX_W-1:0]   iThreshold;
  logic [CNT_W-1:0]   iMinCount;
  logic [COORD_W-1:0] oX;
  logic [COORD_W-1:0] oY;
  logic [CNT_W-1:0]   oCount;
  logic               oFound;
  logic               oBusy;
  logic               oDVAL;
`ifdef BLOB_BBOX_EN
  logic [COORD_W-1:0] oXMin;
  logic [COORD_W-1:0] oXMax;
  logic [COORD_W-1:0] oYMin;
  logic [COORD_W-1:0] oYMax;
`endif

  modport master (
    output iColor, iDVAL, iX_Cont, iY_Cont, iThreshold, iMinCount,
`ifdef BLOB_BBOX_EN
    input  oXMin, oXMax, oYMin, oYMax,
`endif
    input  oX, oY, oCount, oFound, oBusy, oDVAL
  );

  modport slave (
    input  iColor, iDVAL, iX_Cont, iY_Cont, iThreshold, iMinCount,
`ifdef BLOB_BBOX_EN
    output oXMin, oXMax, oYMin, oYMax,
`endif
    output oX, oY, oCount, oFound, oBusy, oDVAL
  );

endinterface

// File: rtl/blob_centroid_det_serial_udiv.sv
// Restoring unsigned divider: first quotient bit is produced on the start edge,
// quotient complete after W edges in total; oDone pulses the cycle it is valid.
module serial_udiv #(
  parameter int W = 8
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iStart,
  input  logic [W-1:0] iDividend,
  input  logic [W-1:0] iDivisor,
  output logic [W-1:0] oQuot,
  output logic         oDone
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvd_r, rem_r, div_r;
  logic [CW-1:0] cnt_r;
  logic          run_r, done_r;
  logic [W-1:0]  remIn_s, dvdIn_s, divIn_s, remNext_s, dvdNext_s;
  logic [W:0]    trial_s;

  // One restoring step on either the fresh operands or the running state
  always_comb begin
    remIn_s   = iStart ? {W{1'b0}} : rem_r;
    dvdIn_s   = iStart ? iDividend : dvd_r;
    divIn_s   = iStart ? iDivisor  : div_r;
    trial_s   = {remIn_s, dvdIn_s[W-1]};
    remNext_s = trial_s[W-1:0];
    dvdNext_s = {dvdIn_s[W-2:0], 1'b0};
    if (trial_s >= {1'b0, divIn_s}) begin
      remNext_s = W'(trial_s - {1'b0, divIn_s});
      dvdNext_s = {dvdIn_s[W-2:0], 1'b1};
    end else begin
      remNext_s = trial_s[W-1:0];
    end
  end

  // Divider state: dividend register shifts out while quotient bits shift in
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      dvd_r  <= {W{1'b0}};
      rem_r  <= {W{1'b0}};
      div_r  <= {W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (iStart) begin
      dvd_r  <= dvdNext_s;
      rem_r  <= remNext_s;
      div_r  <= iDivisor;
      cnt_r  <= CW'(W - 1);
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      dvd_r  <= dvdNext_s;
      rem_r  <= remNext_s;
      cnt_r  <= cnt_r - CW'(1);
      run_r  <= (cnt_r != CW'(1));
      done_r <= (cnt_r == CW'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign oQuot = dvd_r;
  assign oDone = done_r;

endmodule

// File: rtl/blob_centroid_det.sv
// Per-frame thresholded pixel count and exact integer centroid via one shared serial divider.
// Optional bounding-box outputs are enabled by defining BLOB_BBOX_EN.
module blob_centroid_det #(
  parameter int PIX_W   = 12,
  parameter int COORD_W = 11,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input logic               iCLK,
  input logic               iRST,
  blob_centroid_det_if.slave bus
);
  import blob_pkg::*;

  localparam int CNT_W = cntWidth(FRAME_W, FRAME_H);
  localparam int DIV_W = divWidth(CNT_W, COORD_W);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_H - 1);

  blobState_t         state_r, stateNext_s;
  logic               hit_s, frameStart_s, frameEnd_s, found_s;
  logic [CNT_W-1:0]   cntAcc_r, cntBase_s, cntNext_s, snapCnt_r, oCount_r;
  logic [DIV_W-1:0]   sumXAcc_r, sumYAcc_r, sumXBase_s, sumYBase_s, sumXNext_s, sumYNext_s;
  logic [DIV_W-1:0]   snapY_r, divDividend_s, divDivisor_s, divQuot_s;
  logic               snapFound_r, divStart_s, divDone_s;
  logic [COORD_W-1:0] quotX_r, oX_r, oY_r;
  logic               oFound_r, oBusy_r, oDVAL_r;
  logic               unusedQuotHi_s;

  // Hit detection and next accumulator values; a frame start discards the old totals
  always_comb begin
    hit_s        = bus.iDVAL && (bus.iColor > bus.iThreshold);
    frameStart_s = bus.iDVAL && (bus.iX_Cont == {COORD_W{1'b0}}) && (bus.iY_Cont == {COORD_W{1'b0}});
    frameEnd_s   = bus.iDVAL && (bus.iX_Cont == X_LAST) && (bus.iY_Cont == Y_LAST);
    cntBase_s    = frameStart_s ? {CNT_W{1'b0}} : cntAcc_r;
    sumXBase_s   = frameStart_s ? {DIV_W{1'b0}} : sumXAcc_r;
    sumYBase_s   = frameStart_s ? {DIV_W{1'b0}} : sumYAcc_r;
    cntNext_s    = cntBase_s + {{(CNT_W-1){1'b0}}, hit_s};
    sumXNext_s   = sumXBase_s + (hit_s ? {{(DIV_W-COORD_W){1'b0}}, bus.iX_Cont} : {DIV_W{1'b0}});
    sumYNext_s   = sumYBase_s + (hit_s ? {{(DIV_W-COORD_W){1'b0}}, bus.iY_Cont} : {DIV_W{1'b0}});
    found_s      = (cntNext_s >= bus.iMinCount) && (cntNext_s != {CNT_W{1'b0}});
  end

  // Next-state logic and divider launch: X starts on the frame-end edge, Y as X completes
  always_comb begin
    stateNext_s   = state_r;
    divStart_s    = 1'b0;
    divDividend_s = snapY_r;
    divDivisor_s  = {{(DIV_W-CNT_W){1'b0}}, snapCnt_r};
    case (state_r)
      IDLE: begin
        if (frameEnd_s && found_s) begin
          stateNext_s   = DIV_X;
          divStart_s    = 1'b1;
          divDividend_s = sumXNext_s;
          divDivisor_s  = {{(DIV_W-CNT_W){1'b0}}, cntNext_s};
        end else if (frameEnd_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = IDLE;
        end
      end
      DIV_X: begin
        if (divDone_s) begin
          stateNext_s = DIV_Y;
          divStart_s  = 1'b1;
        end else begin
          stateNext_s = DIV_X;
        end
      end
      DIV_Y: begin
        if (divDone_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = DIV_Y;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_r <= IDLE;
    else       state_r <= stateNext_s;
  end

  // Running accumulators, advanced on valid pixels only
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cntAcc_r  <= {CNT_W{1'b0}};
      sumXAcc_r <= {DIV_W{1'b0}};
      sumYAcc_r <= {DIV_W{1'b0}};
    end else if (bus.iDVAL) begin
      cntAcc_r  <= cntNext_s;
      sumXAcc_r <= sumXNext_s;
      sumYAcc_r <= sumYNext_s;
    end
  end

  // Frame-end snapshot; a frame end during a running division is dropped
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      snapCnt_r   <= {CNT_W{1'b0}};
      snapY_r     <= {DIV_W{1'b0}};
      snapFound_r <= 1'b0;
    end else if ((state_r == IDLE) && frameEnd_s) begin
      snapCnt_r   <= cntNext_s;
      snapY_r     <= sumYNext_s;
      snapFound_r <= found_s;
    end
  end

  serial_udiv #(.W(DIV_W)) uDiv (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iStart    (divStart_s),
    .iDividend (divDividend_s),
    .iDivisor  (divDivisor_s),
    .oQuot     (divQuot_s),
    .oDone     (divDone_s)
  );

  assign unusedQuotHi_s = ^divQuot_s[DIV_W-1:COORD_W];

  // X quotient is parked while the divider is reused for Y
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)                                quotX_r <= {COORD_W{1'b0}};
    else if ((state_r == DIV_X) && divDone_s) quotX_r <= divQuot_s[COORD_W-1:0];
  end

  // Result registers; centroid holds its previous value when no blob was found
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oX_r     <= {COORD_W{1'b0}};
      oY_r     <= {COORD_W{1'b0}};
      oCount_r <= {CNT_W{1'b0}};
      oFound_r <= 1'b0;
      oBusy_r  <= 1'b0;
      oDVAL_r  <= 1'b0;
    end else begin
      oBusy_r <= (stateNext_s == DIV_X) || (stateNext_s == DIV_Y);
      oDVAL_r <= (state_r == DONE);
      if (state_r == DONE) begin
        oCount_r <= snapCnt_r;
        oFound_r <= snapFound_r;
        if (snapFound_r) begin
          oX_r <= quotX_r;
          oY_r <= divQuot_s[COORD_W-1:0];
        end
      end
    end
  end

  assign bus.oX     = oX_r;
  assign bus.oY     = oY_r;
  assign bus.oCount = oCount_r;
  assign bus.oFound = oFound_r;
  assign bus.oBusy  = oBusy_r;
  assign bus.oDVAL  = oDVAL_r;

`ifdef BLOB_BBOX_EN
  logic [COORD_W-1:0] xMinAcc_r, xMaxAcc_r, yMinAcc_r, yMaxAcc_r;
  logic [COORD_W-1:0] xMinNext_s, xMaxNext_s, yMinNext_s, yMaxNext_s;
  logic [COORD_W-1:0] snapXMin_r, snapXMax_r, snapYMin_r, snapYMax_r;
  logic [COORD_W-1:0] oXMin_r, oXMax_r, oYMin_r, oYMax_r;

  // Hit bounding box; min starts at all-ones and max at zero each frame
  always_comb begin
    xMinNext_s = frameStart_s ? {COORD_W{1'b1}} : xMinAcc_r;
    xMaxNext_s = frameStart_s ? {COORD_W{1'b0}} : xMaxAcc_r;
    yMinNext_s = frameStart_s ? {COORD_W{1'b1}} : yMinAcc_r;
    yMaxNext_s = frameStart_s ? {COORD_W{1'b0}} : yMaxAcc_r;
    if (hit_s) begin
      xMinNext_s = (bus.iX_Cont < xMinNext_s) ? bus.iX_Cont : xMinNext_s;
      xMaxNext_s = (bus.iX_Cont > xMaxNext_s) ? bus.iX_Cont : xMaxNext_s;
      yMinNext_s = (bus.iY_Cont < yMinNext_s) ? bus.iY_Cont : yMinNext_s;
      yMaxNext_s = (bus.iY_Cont > yMaxNext_s) ? bus.iY_Cont : yMaxNext_s;
    end else begin
      xMinNext_s = xMinNext_s;
    end
  end

  // Bounding-box accumulators, snapshot and result registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      {xMinAcc_r, xMaxAcc_r, yMinAcc_r, yMaxAcc_r}     <= {(4*COORD_W){1'b0}};
      {snapXMin_r, snapXMax_r, snapYMin_r, snapYMax_r} <= {(4*COORD_W){1'b0}};
      {oXMin_r, oXMax_r, oYMin_r, oYMax_r}             <= {(4*COORD_W){1'b0}};
    end else begin
      if (bus.iDVAL)
        {xMinAcc_r, xMaxAcc_r, yMinAcc_r, yMaxAcc_r} <= {xMinNext_s, xMaxNext_s, yMinNext_s, yMaxNext_s};
      if ((state_r == IDLE) && frameEnd_s)
        {snapXMin_r, snapXMax_r, snapYMin_r, snapYMax_r} <= {xMinNext_s, xMaxNext_s, yMinNext_s, yMaxNext_s};
      if ((state_r == DONE) && snapFound_r)
        {oXMin_r, oXMax_r, oYMin_r, oYMax_r} <= {snapXMin_r, snapXMax_r, snapYMin_r, snapYMax_r};
    end
  end

  assign bus.oXMin = oXMin_r;
  assign bus.oXMax = oXMax_r;
  assign bus.oYMin = oYMin_r;
  assign bus.oYMax = oYMax_r;
`endif

endmodule

// File: tb/tb_blob_centroid_det.sv
// Directed bench for blob_centroid_det on an 8x4 frame with a result scoreboard.
module tb_blob_centroid_det;
  localparam int PIX_W     = 12;
  localparam int COORD_W   = 11;
  localparam int FRAME_W   = 8;
  localparam int FRAME_H   = 4;
  localparam int CNT_W     = $clog2(FRAME_W * FRAME_H + 1);
  localparam int DIV_W     = CNT_W + COORD_W;
  localparam int LAT_FOUND = 2 * DIV_W + 1;
  localparam int LAT_MISS  = 1;

  typedef struct {
    int x;
    int y;
    int cnt;
    bit found;
    int lat;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  exp_t sbQ[$];
  int   cmpCount = 0;
  int   errCount = 0;
  int   thr      = 'h700;
  int   minCnt   = 1;
  int   prevX    = 0;
  int   prevY    = 0;

  always #5 iCLK = ~iCLK;

  blob_centroid_det_if #(.PIX_W(PIX_W), .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) bus ();

  blob_centroid_det #(.PIX_W(PIX_W), .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    cmpCount++;
    assert (obs === expv) else begin
      errCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] bitAt(input int x, input int y);
    return 32'd1 << (y * FRAME_W + x);
  endfunction

  task automatic pixel(input int x, input int y, input logic [11:0] c, input logic dv);
    bus.iX_Cont = COORD_W'(x);
    bus.iY_Cont = COORD_W'(y);
    bus.iColor  = c;
    bus.iDVAL   = dv;
    @(posedge iCLK);
    #1;
  endtask

  // Streams one frame and pushes the reference result for it
  task automatic driveFrame(input logic [31:0] mask, input logic [11:0] hitColor, input bit gap);
    int cnt = 0;
    int sx = 0;
    int sy = 0;
    logic [11:0] c;
    exp_t e;
    for (int y = 0; y < FRAME_H; y++) begin
      for (int x = 0; x < FRAME_W; x++) begin
        if (gap && y == 2 && x == 4) begin
          pixel(0, 0, 12'h800, 1'b0);
          for (int g = 1; g < 10; g++) pixel(FRAME_W - 1, FRAME_H - 1, 12'h800, 1'b0);
        end
        c = mask[y * FRAME_W + x] ? hitColor : 12'h100;
        if (int'(c) > thr) begin
          cnt++;
          sx += x;
          sy += y;
        end
        pixel(x, y, c, 1'b1);
      end
    end
    bus.iDVAL = 1'b0;
    e.cnt   = cnt;
    e.found = (cnt >= minCnt) && (cnt != 0);
    e.x     = e.found ? sx / cnt : prevX;
    e.y     = e.found ? sy / cnt : prevY;
    e.lat   = e.found ? LAT_FOUND : LAT_MISS;
    prevX   = e.x;
    prevY   = e.y;
    sbQ.push_back(e);
  endtask

  // Counts cycles from the frame-end edge until oDVAL and compares against the scoreboard
  task automatic waitResult();
    exp_t e;
    bit seen = 1'b0;
    for (int k = 1; k <= LAT_FOUND + 10 && !seen; k++) begin
      @(posedge iCLK);
      #1;
      if (k == 1 && sbQ.size() > 0) check("busy_cycle1", bus.oBusy, sbQ[0].found);
      if (bus.oDVAL) begin
        seen = 1'b1;
        check("sb_has_entry", sbQ.size() > 0, 1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          check("latency", k, e.lat);
          check("oX", bus.oX, e.x);
          check("oY", bus.oY, e.y);
          check("oCount", bus.oCount, e.cnt);
          check("oFound", bus.oFound, e.found);
        end
      end
    end
    check("dval_seen", seen, 1);
    @(posedge iCLK);
    #1;
    check("dval_one_cycle", bus.oDVAL, 0);
    check("busy_after", bus.oBusy, 0);
  endtask

  initial begin
    bit dvalSeen;
    bus.iColor     = 12'h000;
    bus.iDVAL      = 1'b0;
    bus.iX_Cont    = {COORD_W{1'b0}};
    bus.iY_Cont    = {COORD_W{1'b0}};
    bus.iThreshold = 12'h700;
    bus.iMinCount  = CNT_W'(1);

    repeat (2) @(posedge iCLK);
    #1;
    check("rst_oX", bus.oX, 0);
    check("rst_oY", bus.oY, 0);
    check("rst_oCount", bus.oCount, 0);
    check("rst_oFound", bus.oFound, 0);
    check("rst_oBusy", bus.oBusy, 0);
    check("rst_oDVAL", bus.oDVAL, 0);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    driveFrame(bitAt(5, 2), 12'h800, 1'b0);
    waitResult();
    driveFrame(bitAt(2, 1) | bitAt(3, 1), 12'h800, 1'b0);
    waitResult();
    driveFrame(32'd0, 12'h800, 1'b0);
    waitResult();
    driveFrame(bitAt(4, 2), 12'h700, 1'b0);
    waitResult();

    minCnt = 3;
    bus.iMinCount = CNT_W'(3);
    driveFrame(bitAt(2, 1) | bitAt(3, 1), 12'h800, 1'b0);
    waitResult();
    driveFrame(bitAt(1, 0) | bitAt(4, 0) | bitAt(7, 3), 12'h800, 1'b0);
    waitResult();

    minCnt = 1;
    bus.iMinCount = CNT_W'(1);
    driveFrame(bitAt(6, 3) | bitAt(1, 2), 12'h800, 1'b1);
    waitResult();

    // Abort a division part-way through the Y pass
    driveFrame(bitAt(5, 2), 12'h800, 1'b0);
    void'(sbQ.pop_back());
    repeat (25) @(posedge iCLK);
    #1;
    check("busy_in_divy", bus.oBusy, 1);
    #2;
    iRST = 1'b0;
    #1;
    check("abort_oX", bus.oX, 0);
    check("abort_oY", bus.oY, 0);
    check("abort_oCount", bus.oCount, 0);
    check("abort_oFound", bus.oFound, 0);
    check("abort_oBusy", bus.oBusy, 0);
    check("abort_oDVAL", bus.oDVAL, 0);
    @(negedge iCLK);
    iRST = 1'b1;
    prevX = 0;
    prevY = 0;
    dvalSeen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge iCLK);
      #1;
      if (bus.oDVAL) dvalSeen = 1'b1;
    end
    check("no_dval_after_abort", dvalSeen, 0);

    driveFrame(bitAt(0, 0) | bitAt(7, 3) | bitAt(3, 2), 12'h800, 1'b0);
    waitResult();

    check("sb_empty", sbQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/blob_centroid_det.md
Name: blob_centroid_det

Overview:
- Parametrised successor to the threshold group detector in the image-processing pipeline.
- Per frame, counts pixels whose intensity exceeds a runtime threshold and accumulates their X/Y coordinate sums.
- At frame end, a multi-cycle serial divider produces the exact integer centroid, plus pixel count and a found/not-found flag.
- Sits after the grayscale/colour-channel stage and feeds the tracking/VGA overlay logic.

Parameters:
- PIX_W, 12, pixel intensity width.
- COORD_W, 11, width of X/Y coordinates and centroid outputs.
- FRAME_W, 640, active pixels per line; last column is FRAME_W-1.
- FRAME_H, 480, active lines per frame; last row is FRAME_H-1.
- Derived localparams: CNT_W = $clog2(FRAME_W*FRAME_H+1); DIV_W = CNT_W+COORD_W.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous, active-low reset.
- iColor  in  PIX_W  pixel intensity.
- iDVAL  in  1  pixel valid qualifier.
- iX_Cont  in  COORD_W  current column.
- iY_Cont  in  COORD_W  current row.
- iThreshold  in  PIX_W  detection threshold (strict >); sampled every valid pixel.
- iMinCount  in  CNT_W  minimum hit count for a valid blob.
- oX  out  COORD_W  centroid column, floor(sumX/count).
- oY  out  COORD_W  centroid row, floor(sumY/count).
- oCount  out  CNT_W  hit count of the last completed frame.
- oFound  out  1  last frame had count >= iMinCount and count > 0.
- oBusy  out  1  divider running.
- oDVAL  out  1  one-cycle pulse when all outputs update.

Behaviour:
- Reset: all outputs 0; accumulators 0; FSM in IDLE. Reset asserted mid-division aborts it with no oDVAL.
- Hit condition: iDVAL && iColor > iThreshold.
- Accumulators: cnt (CNT_W), sumX and sumY (DIV_W each). Sized so they never overflow; no saturation logic.
- Frame start (iDVAL, X==0, Y==0): accumulators load that pixel's contribution: hit ? {1, 0, 0} : 0. The previous frame is discarded.
- Frame end (iDVAL, X==FRAME_W-1, Y==FRAME_H-1):
  - Final totals, including this pixel, are snapshotted into divider registers.
  - Accumulation of the next frame is unaffected by the snapshot.
- FSM states: IDLE, DIV_X, DIV_Y, DONE.
- IDLE -> DIV_X on frame end when cnt_final >= iMinCount and cnt_final != 0.
  - Otherwise IDLE -> DONE directly: oFound=0, oCount updated, oX/oY hold previous values.
- DIV_X: restoring divider, one quotient bit per cycle, DIV_W cycles; then DIV_Y for the same DIV_W cycles; then DONE.
- DONE: one cycle. Registers oX/oY (low COORD_W bits of the quotients), oCount, oFound; pulses oDVAL; returns to IDLE.
- Latency, measured from the frame-end pixel edge (cycle 0):
  - Found case: oDVAL high in cycle 2*DIV_W+1.
  - Not-found case: oDVAL high in cycle 1.
- oBusy is high in DIV_X and DIV_Y.
- A frame end while oBusy is ignored; the running division completes. This cannot occur at legal frame sizes.
- Pixels with iDVAL=0 are ignored entirely, including for frame start/end detection.

Optional Feature:
- Macro BLOB_BBOX_EN.
- When defined, adds ports oXMin, oXMax, oYMin, oYMax (out, COORD_W each).
  - Min/max of hit coordinates, tracked alongside the accumulators.
  - Min registers reset per frame to all-ones; max registers reset to 0.
  - Registered in DONE together with the centroid.
  - When not found, they hold previous values.
  - Reset value 0.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package blob_pkg: FSM state enum typedef (IDLE/DIV_X/DIV_Y/DONE) and a width helper function for CNT_W/DIV_W.
- Sub-module serial_udiv (parameter W): start/done handshake, W-cycle restoring unsigned divider. Instantiated once and reused for X then Y.

Test Plan:
- FRAME_W=8, FRAME_H=4, iThreshold=0x700, iMinCount=1. Single hit 0x800 at (5,2) -> oX=5, oY=2, oCount=1, oFound=1, oDVAL at cycle 2*DIV_W+1 after pixel (7,3).
- Hits at (2,1) and (3,1) -> oX=2 (floor of 2.5), oY=1, oCount=2.
- No pixel above threshold, or iColor == iThreshold exactly -> oDVAL at cycle 1, oFound=0, oCount=0, oX/oY unchanged from prior frame.
- iMinCount=3 with 2 hits -> oFound=0, oCount=2; next frame with 3 hits at (1,0), (4,0), (7,3) -> oX=4, oY=1, oFound=1.
- iDVAL deasserted for 10 cycles mid-line, and a hit pixel presented with iDVAL=0 -> results identical to the gap-free stream.
- iRST pulsed during DIV_Y -> all outputs 0, no oDVAL; the following frame computes normally.
